vl_rec_arbiter: RTL and testbench



---
 rtl/vl_rec_arbiter_if.sv | 24 ++
 rtl/vl_rec_arbiter.sv | 91 +++++++++
 tb/tb_vl_rec_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vl_rec_arbiter_if.sv
// Requester/sink bundle for vl_rec_arbiter.
// The arbiter uses the slave modport. The requester/sink side uses the master modport.
interface vl_rec_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int PAYLOAD_W = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload;
  logic [NUM_REQ-1:0]           req_ready;
  logic [PAYLOAD_W:0]           rec_out;
  logic [$clog2(NUM_REQ)-1:0]   rec_src;
  logic                         busy;
  logic [15:0]                  xfer_count;

  modport master (
    output req_valid, req_payload,
    input  req_ready, rec_out, rec_src, busy, xfer_count
  );

  modport slave (
    input  req_valid, req_payload,
    output req_ready, rec_out, rec_src, busy, xfer_count
  );
endinterface

// File: rtl/vl_rec_arbiter.sv
// Round-robin arbiter that feeds one vl_rec sink.
// It owns the record's vl_bit and toggles it once per delivered record,
// so the sink sees an event even when two consecutive payloads are identical.
// Each record is held stable for HOLD_CYCLES cycles before the next grant.
module vl_rec_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PAYLOAD_W   = 8,
  parameter int HOLD_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  vl_rec_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      last, win;
  logic               any;
  logic               grant;
  logic [NUM_REQ-1:0] ready;
  logic [CW-1:0]      hold_cnt;
  logic [PAYLOAD_W:0] rec;
  logic [IW-1:0]      src;
  logic [15:0]        cnt_q;
  int                 idx;

  // Round-robin search. The loop walks from the farthest candidate to the
  // nearest one, so the final assignment is the first valid index after last.
  always_comb begin
    win = last;
    any = 1'b0;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        win = idx[IW-1:0];
        any = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and accept strobe. Reset masks any grant in the same cycle.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ready     = '0;
    case (state)
      IDLE: if (any && !rst) begin
        grant      = 1'b1;
        ready[win] = 1'b1;
        state_nxt  = HOLD;
      end
      HOLD: if (hold_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Record capture, vl_bit toggle, pointer update, hold countdown and delivery count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rec      <= '0;
      src      <= '0;
      last     <= IW'(NUM_REQ - 1);
      cnt_q    <= '0;
      hold_cnt <= '0;
    end else if (grant) begin
      rec      <= {bus.req_payload[int'(win)*PAYLOAD_W +: PAYLOAD_W], ~rec[0]};
      src      <= win;
      last     <= win;
      cnt_q    <= cnt_q + 16'd1;
      hold_cnt <= CW'(HOLD_CYCLES - 1);
    end else if (state == HOLD && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rec_out    = rec;
  assign bus.rec_src    = src;
  assign bus.busy       = (state == HOLD);
  assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_vl_rec_arbiter.sv
// Bench for vl_rec_arbiter.
// Directed vector table, hand-written sequences and randomized traffic are all
// checked against a cycle-level reference model built from the arbitration rules.
module tb_vl_rec_arbiter;
  localparam int N = 4, PW = 8, HC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vl_rec_arbiter_if #(.NUM_REQ(N), .PAYLOAD_W(PW)) bif ();

  vl_rec_arbiter #(.NUM_REQ(N), .PAYLOAD_W(PW), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  int n_vec = 0, n_err = 0;

  // Reference model state.
  int          m_last, m_busy, m_src;
  logic [8:0]  m_rec;
  logic [15:0] m_cnt;

  // Last sampled DUT outputs.
  logic [3:0]  obs_ready;
  logic [8:0]  obs_rec;
  logic [1:0]  obs_src;
  logic        obs_busy;
  logic [15:0] obs_cnt, prev_cnt;
  int          cyc = 0;
  int          log_src[$], log_vl[$], log_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_busy = 0; m_src = 0; m_rec = '0; m_cnt = '0;
  endtask

  // Runs one clock cycle: drive inputs, sample and check at negedge, then advance the model at posedge.
  task automatic do_cycle(input logic r, input logic [3:0] v, input logic [31:0] p);
    int g;
    logic [3:0] exp_ready;
    rst = r; bif.req_valid = v; bif.req_payload = p;
    @(negedge clk);
    g = (!r && m_busy == 0) ? rr_pick(m_last, v) : -1;
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0;
    obs_ready = bif.req_ready; obs_rec = bif.rec_out; obs_src = bif.rec_src;
    obs_busy = bif.busy; obs_cnt = bif.xfer_count;
    chk("m_ready", 32'(obs_ready), 32'(exp_ready));
    chk("m_rec",   32'(obs_rec),   32'(m_rec));
    chk("m_src",   32'(obs_src),   32'(m_src));
    chk("m_busy",  32'(obs_busy),  32'(m_busy > 0));
    chk("m_cnt",   32'(obs_cnt),   32'(m_cnt));
    if (obs_cnt != prev_cnt && obs_cnt != 16'd0) begin
      log_src.push_back(int'(obs_src)); log_vl.push_back(int'(obs_rec[0])); log_cyc.push_back(cyc);
    end
    prev_cnt = obs_cnt;
    @(posedge clk);
    if (r) model_reset();
    else if (g >= 0) begin
      m_rec = {p[g*PW +: PW], ~m_rec[0]};
      m_src = g; m_last = g; m_cnt = m_cnt + 16'd1; m_busy = HC;
    end else if (m_busy > 0) m_busy--;
    cyc++;
    #1;
  endtask

  typedef struct {
    logic r; logic [3:0] v; logic [31:0] p;
    logic [3:0] ready; logic [8:0] rec; logic [1:0] src; logic busy; logic [15:0] cnt;
  } vec_t;
  vec_t tbl[24];

  localparam logic [31:0] P1 = 32'h00A50000, P2 = 32'h0000003C, P3 = 32'h13121110;

  initial begin
    tbl[0]  = '{1'b1, 4'h0, P1, 4'h0, 9'h000, 2'd0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 4'h4, P1, 4'h4, 9'h000, 2'd0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 4'h4, P1, 4'h0, 9'h14B, 2'd2, 1'b1, 16'd1};
    tbl[3]  = '{1'b0, 4'h4, P1, 4'h0, 9'h14B, 2'd2, 1'b1, 16'd1};
    tbl[4]  = '{1'b0, 4'h4, P1, 4'h4, 9'h14B, 2'd2, 1'b0, 16'd1};
    tbl[5]  = '{1'b0, 4'h0, P1, 4'h0, 9'h14A, 2'd2, 1'b1, 16'd2};
    tbl[6]  = '{1'b0, 4'h0, P1, 4'h0, 9'h14A, 2'd2, 1'b1, 16'd2};
    tbl[7]  = '{1'b0, 4'h0, P1, 4'h0, 9'h14A, 2'd2, 1'b0, 16'd2};
    tbl[8]  = '{1'b0, 4'h1, P2, 4'h1, 9'h14A, 2'd2, 1'b0, 16'd2};
    tbl[9]  = '{1'b1, 4'h0, P2, 4'h0, 9'h079, 2'd0, 1'b1, 16'd3};
    tbl[10] = '{1'b0, 4'hA, P3, 4'h2, 9'h000, 2'd0, 1'b0, 16'd0};
    tbl[11] = '{1'b0, 4'hA, P3, 4'h0, 9'h023, 2'd1, 1'b1, 16'd1};
    tbl[12] = '{1'b0, 4'hA, P3, 4'h0, 9'h023, 2'd1, 1'b1, 16'd1};
    tbl[13] = '{1'b0, 4'hA, P3, 4'h8, 9'h023, 2'd1, 1'b0, 16'd1};
    tbl[14] = '{1'b0, 4'h6, P3, 4'h0, 9'h026, 2'd3, 1'b1, 16'd2};
    tbl[15] = '{1'b0, 4'h6, P3, 4'h0, 9'h026, 2'd3, 1'b1, 16'd2};
    tbl[16] = '{1'b0, 4'h6, P3, 4'h2, 9'h026, 2'd3, 1'b0, 16'd2};
    tbl[17] = '{1'b0, 4'h6, P3, 4'h0, 9'h023, 2'd1, 1'b1, 16'd3};
    tbl[18] = '{1'b0, 4'h6, P3, 4'h0, 9'h023, 2'd1, 1'b1, 16'd3};
    tbl[19] = '{1'b0, 4'h6, P3, 4'h4, 9'h023, 2'd1, 1'b0, 16'd3};
    tbl[20] = '{1'b0, 4'h6, P3, 4'h0, 9'h024, 2'd2, 1'b1, 16'd4};
    tbl[21] = '{1'b0, 4'h6, P3, 4'h0, 9'h024, 2'd2, 1'b1, 16'd4};
    tbl[22] = '{1'b0, 4'h6, P3, 4'h2, 9'h024, 2'd2, 1'b0, 16'd4};
    tbl[23] = '{1'b0, 4'h6, P3, 4'h0, 9'h023, 2'd1, 1'b1, 16'd5};

    // Initial reset. Outputs are unknown until the first reset edge.
    rst = 1'b1; bif.req_valid = '0; bif.req_payload = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    prev_cnt = '0;

    // Directed table: reset, single requester, reset mid-HOLD, pointer wrap and skip.
    for (int i = 0; i < 24; i++) begin
      do_cycle(tbl[i].r, tbl[i].v, tbl[i].p);
      chk($sformatf("t%0d_ready", i), 32'(obs_ready), 32'(tbl[i].ready));
      chk($sformatf("t%0d_rec",   i), 32'(obs_rec),   32'(tbl[i].rec));
      chk($sformatf("t%0d_src",   i), 32'(obs_src),   32'(tbl[i].src));
      chk($sformatf("t%0d_busy",  i), 32'(obs_busy),  32'(tbl[i].busy));
      chk($sformatf("t%0d_cnt",   i), 32'(obs_cnt),   32'(tbl[i].cnt));
    end

    // All requesters valid for 12 cycles: grants 0,1,2,3 spaced 3 cycles, vl 1,0,1,0.
    do_cycle(1'b1, 4'h0, P3);
    log_src.delete(); log_vl.delete(); log_cyc.delete();
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 4'hF, P3);
    do_cycle(1'b0, 4'h0, P3);
    chk("fair_cnt", 32'(obs_cnt), 32'd4);
    chk("fair_nrec", 32'(log_src.size()), 32'd4);
    if (log_src.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("fair_src%0d", i), 32'(log_src[i]), 32'(i));
        chk($sformatf("fair_vl%0d", i), 32'(log_vl[i]), 32'((i + 1) % 2));
        if (i > 0) chk($sformatf("fair_gap%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd3);
      end

    // Counter wrap: preload 0xFFFF, then deliver one record.
    do_cycle(1'b0, 4'h0, P3);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFF;
    do_cycle(1'b0, 4'h0, P3);
    chk("wrap_pre", 32'(obs_cnt), 32'hFFFF);
    do_cycle(1'b0, 4'h1, 32'h000000E7);
    do_cycle(1'b0, 4'h0, P3);
    chk("wrap_cnt", 32'(obs_cnt), 32'd0);
    chk("wrap_rec", 32'(obs_rec[8:1]), 32'hE7);
    chk("wrap_src", 32'(obs_src), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      do_cycle(($urandom_range(0, 39) == 0), 4'($urandom), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
